// File: rtl/bitmap_pkg.sv
// Shared constants and state types for the tile bitmap fetch path.
// Imported by every file of the bitmap_fetch_ctrl slice.
package bitmap_pkg;

  localparam int COLS      = 40;
  localparam int TILE_LOG2 = 4;
  localparam int CHAR_BITS = 4;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } cpu_state_t;

endpackage

// File: rtl/bitmap_fetch_ctrl_sig_delay.sv
// Parameterised W-bit, D-deep register chain used to keep the
// active/hsync/vsync flags aligned with the memory pipeline.
module sig_delay #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  import bitmap_pkg::*;

  logic [W-1:0] pipe_q [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < D; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[D-1];

endmodule

// File: rtl/bitmap_fetch_ctrl.sv
// Tile bitmap fetch pipeline with display-priority CPU read port.
// Define BITMAP_CPU_STEAL_EN to let the CPU steal one display cycle.
module bitmap_fetch_ctrl #(
  parameter int Abits     = 12,
  parameter int Dbits     = 12,
  parameter int SAbits    = 11,
  parameter int CHAR_BITS = bitmap_pkg::CHAR_BITS,
  parameter int COLS      = bitmap_pkg::COLS,
  parameter int TILE_LOG2 = bitmap_pkg::TILE_LOG2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 active_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  output logic [SAbits-1:0]    screen_addr,
  input  logic [CHAR_BITS-1:0] char_code,
  output logic [Abits-1:0]     bitmap_addr,
  input  logic [Dbits-1:0]     color_value,
  input  logic                 cpu_req,
  input  logic [Abits-1:0]     cpu_addr,
  output logic                 cpu_ack,
  output logic [Dbits-1:0]     cpu_rdata,
  output logic [Dbits-1:0]     rgb,
  output logic                 hsync,
  output logic                 vsync
);
  import bitmap_pkg::*;

  logic                 act1;
  logic                 hs1;
  logic                 vs1;
  logic [SAbits-1:0]    screen_addr_q;
  logic [SAbits-1:0]    screen_addr_d;
  logic [TILE_LOG2-1:0] xl_q;
  logic [TILE_LOG2-1:0] yl_q;
  logic [Dbits-1:0]     rgb_q;
  logic [Dbits-1:0]     rgb_d;
  logic [Dbits-1:0]     cpu_rdata_q;
  logic [Abits-1:0]     cpu_addr_q;
  logic [Abits-1:0]     disp_addr;
  cpu_state_t           state_q;
  cpu_state_t           state_d;
  logic                 accept;
  logic                 capture;
`ifdef BITMAP_CPU_STEAL_EN
  logic                 steal_q;
  logic                 steal_d;
`endif

  sig_delay #(
    .W (3),
    .D (1)
  ) u_stage1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({active_in, hsync_in, vsync_in}),
    .q_o   ({act1, hs1, vs1})
  );

  sig_delay #(
    .W (2),
    .D (1)
  ) u_stage2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({hs1, vs1}),
    .q_o   ({hsync, vsync})
  );

  // Arithmetic done at SAbits width: wraps exactly like truncation.
  assign screen_addr_d = SAbits'(y >> TILE_LOG2) * SAbits'(COLS)
                       + SAbits'(x >> TILE_LOG2);

  assign disp_addr = {char_code, yl_q, xl_q};

  always_comb begin
    bitmap_addr = disp_addr;
    if (!act1 && state_q == WAIT) begin
      bitmap_addr = cpu_addr_q;
    end
`ifdef BITMAP_CPU_STEAL_EN
    if (steal_q) begin
      bitmap_addr = cpu_addr_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
`ifdef BITMAP_CPU_STEAL_EN
        if (steal_q) begin
`else
        if (!act1) begin
`endif
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef BITMAP_CPU_STEAL_EN
  // First WAIT cycle arms the steal; the following cycle owns the port.
  assign steal_d = (state_q == WAIT) && !steal_q;
`endif

  always_comb begin
    rgb_d = act1 ? color_value : '0;
`ifdef BITMAP_CPU_STEAL_EN
    if (steal_q) begin
      rgb_d = rgb_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      screen_addr_q <= '0;
      xl_q          <= '0;
      yl_q          <= '0;
      rgb_q         <= '0;
      cpu_addr_q    <= '0;
      cpu_rdata_q   <= '0;
      state_q       <= IDLE;
`ifdef BITMAP_CPU_STEAL_EN
      steal_q       <= 1'b0;
`endif
    end else begin
      screen_addr_q <= screen_addr_d;
      xl_q          <= x[TILE_LOG2-1:0];
      yl_q          <= y[TILE_LOG2-1:0];
      rgb_q         <= rgb_d;
      state_q       <= state_d;
      if (accept) begin
        cpu_addr_q <= cpu_addr;
      end
      if (capture) begin
        cpu_rdata_q <= color_value;
      end
`ifdef BITMAP_CPU_STEAL_EN
      steal_q       <= steal_d;
`endif
    end
  end

  assign screen_addr = screen_addr_q;
  assign rgb         = rgb_q;
  assign cpu_ack     = (state_q == ACK);
  assign cpu_rdata   = cpu_rdata_q;

endmodule

// File: tb/tb_bitmap_fetch_ctrl.sv
// Directed self-checking bench for bitmap_fetch_ctrl.
// Bitmap memory modelled as a small combinational lookup.
module tb_bitmap_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [10:0] screen_addr;
  logic [3:0]  char_code;
  logic [11:0] bitmap_addr;
  logic [11:0] color_value;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic        cpu_ack;
  logic [11:0] cpu_rdata;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;

  int n_cmp = 0;
  int n_bad = 0;

  bitmap_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .active_in   (active_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .screen_addr (screen_addr),
    .char_code   (char_code),
    .bitmap_addr (bitmap_addr),
    .color_value (color_value),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync)
  );

  function automatic logic [11:0] bmp(input logic [11:0] a);
    case (a)
      12'h343: return 12'hABC;
      12'h100: return 12'h0F0;
      12'h2A5: return 12'h777;
      default: return {a[3:0], a[7:4], a[11:8]};
    endcase
  endfunction

  always_comb color_value = bmp(bitmap_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_cmp++;
    if (screen_addr !== 11'd0) begin
      n_bad++;
      $display("FAIL rst_screen_addr got %h want 0", screen_addr);
    end
    n_cmp++;
    if (rgb !== 12'h000) begin
      n_bad++;
      $display("FAIL rst_rgb got %h want 0", rgb);
    end
    n_cmp++;
    if (hsync !== 1'b0 || vsync !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_sync got %b%b want 00", hsync, vsync);
    end
    n_cmp++;
    if (cpu_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ack got %b want 0", cpu_ack);
    end
    n_cmp++;
    if (cpu_rdata !== 12'h000) begin
      n_bad++;
      $display("FAIL rst_rdata got %h want 0", cpu_rdata);
    end
  endtask

  task automatic test_pipeline;
    x = 10'd35;
    y = 10'd20;
    active_in = 1'b1;
    char_code = 4'd3;
    tick;
    active_in = 1'b0;
    n_cmp++;
    if (screen_addr !== 11'd42) begin
      n_bad++;
      $display("FAIL pipe_screen_addr got %0d want 42", screen_addr);
    end
    n_cmp++;
    if (bitmap_addr !== 12'h343) begin
      n_bad++;
      $display("FAIL pipe_bitmap_addr got %h want 343", bitmap_addr);
    end
    n_cmp++;
    if (rgb !== 12'h000) begin
      n_bad++;
      $display("FAIL pipe_rgb_early got %h want 000", rgb);
    end
    tick;
    n_cmp++;
    if (rgb !== 12'hABC) begin
      n_bad++;
      $display("FAIL pipe_rgb got %h want abc", rgb);
    end
    tick;
    n_cmp++;
    if (rgb !== 12'h000) begin
      n_bad++;
      $display("FAIL pipe_rgb_blank got %h want 000", rgb);
    end
  endtask

  task automatic test_sync;
    logic eh;
    logic ev;
    for (int i = 0; i < 106; i++) begin
      active_in = 1'b0;
      x = 10'(i);
      hsync_in = (i >= 2 && i < 98);
      vsync_in = (i >= 10 && i < 13);
      tick;
      eh = (i >= 3 && i < 99);
      ev = (i >= 11 && i < 14);
      n_cmp++;
      if (hsync !== eh) begin
        n_bad++;
        $display("FAIL sync_h[%0d] got %b want %b", i, hsync, eh);
      end
      n_cmp++;
      if (vsync !== ev) begin
        n_bad++;
        $display("FAIL sync_v[%0d] got %b want %b", i, vsync, ev);
      end
      n_cmp++;
      if (rgb !== 12'h000) begin
        n_bad++;
        $display("FAIL sync_rgb[%0d] got %h want 000", i, rgb);
      end
    end
    hsync_in = 1'b0;
    vsync_in = 1'b0;
  endtask

  task automatic test_cpu_blank(input logic [11:0] a,
                                input logic [11:0] d);
    active_in = 1'b0;
    cpu_addr = a;
    cpu_req = 1'b1;
    tick;
    cpu_req = 1'b0;
    cpu_addr = 12'hFFF;
    n_cmp++;
    if (bitmap_addr !== a) begin
      n_bad++;
      $display("FAIL blank_port got %h want %h", bitmap_addr, a);
    end
    n_cmp++;
    if (cpu_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL blank_ack_early got %b want 0", cpu_ack);
    end
`ifdef BITMAP_CPU_STEAL_EN
    tick;
    n_cmp++;
    if (cpu_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL blank_ack_steal got %b want 0", cpu_ack);
    end
`endif
    tick;
    n_cmp++;
    if (cpu_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL blank_ack got %b want 1", cpu_ack);
    end
    n_cmp++;
    if (cpu_rdata !== d) begin
      n_bad++;
      $display("FAIL blank_rdata got %h want %h", cpu_rdata, d);
    end
    tick;
    n_cmp++;
    if (cpu_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL blank_ack_pulse got %b want 0", cpu_ack);
    end
    n_cmp++;
    if (cpu_rdata !== d) begin
      n_bad++;
      $display("FAIL blank_rdata_hold got %h want %h", cpu_rdata, d);
    end
  endtask

  task automatic test_cpu_active;
    logic [11:0] er [9];
    int          ak;
    er = '{12'h000, 12'h843, 12'h943, 12'hA43, 12'hB43,
           12'hC43, 12'h000, 12'h000, 12'h000};
`ifdef BITMAP_CPU_STEAL_EN
    er[2] = 12'h843;
    ak = 2;
`else
    ak = 6;
`endif
    y = 10'd20;
    char_code = 4'd3;
    for (int k = 0; k < 9; k++) begin
      active_in = (k <= 4);
      x = 10'(40 + k);
      cpu_req = (k == 0);
      cpu_addr = (k == 0) ? 12'h2A5 : 12'h100;
      tick;
      n_cmp++;
      if (rgb !== er[k]) begin
        n_bad++;
        $display("FAIL act_rgb[%0d] got %h want %h", k, rgb, er[k]);
      end
      n_cmp++;
      if (cpu_ack !== (k == ak)) begin
        n_bad++;
        $display("FAIL act_ack[%0d] got %b want %b", k, cpu_ack, k == ak);
      end
    end
    n_cmp++;
    if (cpu_rdata !== 12'h777) begin
      n_bad++;
      $display("FAIL act_rdata got %h want 777", cpu_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int a1;
    int a2;
`ifdef BITMAP_CPU_STEAL_EN
    a1 = 2;
    a2 = 6;
`else
    a1 = 1;
    a2 = 4;
`endif
    active_in = 1'b0;
    cpu_req = 1'b1;
    cpu_addr = 12'h100;
    for (int k = 0; k <= a2 + 2; k++) begin
      tick;
      if (k == a1) cpu_addr = 12'h2A5;
      if (k == a2) cpu_req = 1'b0;
      n_cmp++;
      if (cpu_ack !== (k == a1 || k == a2)) begin
        n_bad++;
        $display("FAIL b2b_ack[%0d] got %b want %b", k, cpu_ack,
                 k == a1 || k == a2);
      end
      if (k == a2) begin
        n_cmp++;
        if (cpu_rdata !== 12'h777) begin
          n_bad++;
          $display("FAIL b2b_rdata got %h want 777", cpu_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    active_in = 1'b1;
    x = 10'd40;
    y = 10'd20;
    cpu_req = 1'b1;
    cpu_addr = 12'h100;
    tick;
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      tick;
      n_cmp++;
      if (cpu_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL rmid_ack[%0d] got %b want 0", k, cpu_ack);
      end
    end
    active_in = 1'b0;
    rst_n = 1'b1;
    #1;
    test_reset;
    tick;
    n_cmp++;
    if (cpu_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_idle_ack got %b want 0", cpu_ack);
    end
    test_cpu_blank(12'h2A5, 12'h777);
  endtask

  task automatic test_boundary;
    char_code = 4'd3;
    x = 10'd639;
    y = 10'd479;
    active_in = 1'b1;
    tick;
    n_cmp++;
    if (screen_addr !== 11'd1199) begin
      n_bad++;
      $display("FAIL bnd_sa_639 got %0d want 1199", screen_addr);
    end
    x = 10'd640;
    active_in = 1'b0;
    tick;
    n_cmp++;
    if (screen_addr !== 11'd1200) begin
      n_bad++;
      $display("FAIL bnd_sa_640 got %0d want 1200", screen_addr);
    end
    n_cmp++;
    if (rgb !== 12'hFF3) begin
      n_bad++;
      $display("FAIL bnd_rgb_639 got %h want ff3", rgb);
    end
    tick;
    n_cmp++;
    if (rgb !== 12'h000) begin
      n_bad++;
      $display("FAIL bnd_rgb_640 got %h want 000", rgb);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    x = '0;
    y = '0;
    active_in = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    char_code = '0;
    cpu_req = 1'b0;
    cpu_addr = '0;
    #2;
    test_reset;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_pipeline;
    test_sync;
    test_cpu_blank(12'h100, 12'h0F0);
    test_cpu_active;
    test_back_to_back;
    test_reset_mid;
    test_boundary;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bitmap_fetch_ctrl.md
Name: bitmap_fetch_ctrl

Overview:
- Sequences the tile bitmap memory for the VGA display path.
  - Converts pixel coordinates into a screen-memory address.
  - Combines the returned character code with the in-tile pixel offset to form the bitmap address.
  - Registers the colour and sync outputs with matched latency.
- Also arbitrates the single bitmap read port between the display pipeline (priority) and a CPU debug/read requester.
- Sits between the VGA timer, screen memory, bitmap memory and the VGA output pins.

Parameters:
- Abits, 12, bitmap address width; equals CHAR_BITS + 2*TILE_LOG2.
- Dbits, 12, colour width (4:4:4 RGB).
- SAbits, 11, screen memory address width.
- CHAR_BITS, 4, character code width.
- COLS, 40, tiles per screen row.
- TILE_LOG2, 4, log2 of tile edge in pixels (16x16 tiles).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x  in  10  pixel column from VGA timer.
- y  in  10  pixel row from VGA timer.
- active_in  in  1  visible-region flag.
- hsync_in  in  1  horizontal sync from timer.
- vsync_in  in  1  vertical sync from timer.
- screen_addr  out  SAbits  screen memory read address (registered).
- char_code  in  CHAR_BITS  combinational screen memory read data.
- bitmap_addr  out  Abits  bitmap memory read address (combinational mux).
- color_value  in  Dbits  combinational bitmap memory read data.
- cpu_req  in  1  CPU read request (level).
- cpu_addr  in  Abits  CPU read address.
- cpu_ack  out  1  one-cycle pulse; cpu_rdata valid this cycle.
- cpu_rdata  out  Dbits  CPU read data (held until next ack).
- rgb  out  Dbits  pixel colour.
- hsync  out  1  delayed hsync.
- vsync  out  1  delayed vsync.

Behaviour:
- Reset (async, rst_n=0), all registers cleared: screen_addr=0, rgb=0, hsync=0, vsync=0, cpu_ack=0, cpu_rdata=0, FSM=IDLE, pipeline valid bits=0.
- Stage 1 (edge N+1):
  - screen_addr <= (y>>TILE_LOG2)*COLS + (x>>TILE_LOG2), truncated to SAbits.
  - Latch xl=x[TILE_LOG2-1:0], yl=y[TILE_LOG2-1:0], act1=active_in, hs1, vs1.
- Stage 2, cycle N+1: display address = {char_code, yl, xl}.
- Edge N+2:
  - rgb <= act1 ? color_value : 0.
  - hsync/vsync <= hs1/vs1.
  - Total latency: 2 clocks, identical for colour and syncs.
- Port mux: bitmap_addr = display address when act1=1; otherwise cpu_addr_q when FSM=WAIT; otherwise display address.
- CPU FSM:
  - IDLE: on cpu_req=1, latch cpu_addr_q, go WAIT.
  - WAIT: if act1=0, cpu_rdata <= color_value, go ACK; else stay.
  - ACK: cpu_ack=1 for this cycle only, go IDLE.
- Handshake rules:
  - A request is accepted only in IDLE.
  - cpu_req still high in IDLE after ACK starts a new transaction.
  - cpu_addr changes after acceptance are ignored.
- Boundaries and simultaneous events:
  - Worst-case CPU wait is one visible line; there is no timeout.
  - Inactive pixels (x>=640 or y>=480) still compute screen_addr, but rgb is forced to 0.
  - cpu_req rising in the same cycle as act1 rising: the request is latched, then waits.
  - Reset mid-transaction aborts it; no ack is issued.

Optional Feature:
- Macro: BITMAP_CPU_STEAL_EN.
- Defined:
  - In WAIT the CPU wins the port on the next cycle regardless of act1.
  - On that stolen cycle, rgb repeats its previous value instead of sampling color_value.
  - CPU latency is fixed at 3 clocks from acceptance to ack.
- Undefined: blanking-only CPU access as above.

Decomposition:
- Package bitmap_pkg:
  - Constants COLS, TILE_LOG2, CHAR_BITS, H_VISIBLE=640, V_VISIBLE=480.
  - Enum cpu_state_t {IDLE, WAIT, ACK}.
- One sub-module, sig_delay: parameterised width/depth register chain used for the act/hsync/vsync alignment.

Test Plan:
- x=35, y=20, active_in=1 -> screen_addr=42 one clock later. Drive char_code=3 -> bitmap_addr=0x343. Drive color_value=0xABC -> rgb=0xABC two clocks after the inputs.
- hsync_in pulse of 96 clocks -> hsync is the identical pulse delayed exactly 2 clocks; rgb=0 while active_in=0 regardless of color_value.
- cpu_req with cpu_addr=0x100 during blanking -> bitmap_addr=0x100 in WAIT. Return color_value=0x0F0 -> cpu_ack one cycle, cpu_rdata=0x0F0 held afterwards.
- cpu_req during active video -> no ack until the first act1=0 cycle. rgb stream is unchanged; with BITMAP_CPU_STEAL_EN, ack comes 3 clocks after acceptance and one rgb value repeats.
- rst_n asserted in WAIT, released 5 clocks later -> no cpu_ack, all outputs 0, FSM IDLE. A fresh request then completes normally.
- x=639, y=479 -> screen_addr=1199. x=640 -> rgb=0.
